// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared state type, index width and requester ids for the data memory arbiter.
package data_mem_arb_pkg;
    localparam int N_REQ = 3;
    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] REQ_STACK = IDX_W'(0);
    localparam logic [IDX_W-1:0] REQ_LDST = IDX_W'(1);
    localparam logic [IDX_W-1:0] REQ_INPUT = IDX_W'(2);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/data_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting just after last_grant.
module rr_pick
    import data_mem_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] winner,
    output logic             any
);
    logic [IDX_W-1:0] cand;
    // Scan farthest-first so the nearest requester after last_grant overwrites.
    always_comb begin
        winner = last_grant;
        any = 1'b0;
        cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (req[cand]) begin
                winner = cand;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: registered round-robin request/grant arbiter sharing the single-port
// data memory between the stack unit, the load/store path and the input loader.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    busy
);
    state_t state, state_nxt;
    logic [IDX_W-1:0] idx, last_grant, winner;
    logic [N_REQ-1:0] idx_oh;
    logic l_we, any;

    rr_pick u_pick (.req(req), .last_grant(last_grant), .winner(winner), .any(any));

    // mem_addr/mem_wdata are the latched request, so they hold outside ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx <= '0;
            last_grant <= REQ_INPUT;
            l_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any) begin
                idx <= winner;
                last_grant <= winner;
                l_we <= we[winner];
                mem_addr <= addr[winner*ADDR_W +: ADDR_W];
                mem_wdata <= wdata[winner*DATA_W +: DATA_W];
            end
            if (state == ACCESS && !l_we) rdata <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        idx_oh = N_REQ'(1) << idx;
        gnt = '0;
        rvalid = '0;
        mem_we = 1'b0;
        case (state)
            IDLE: state_nxt = any ? ACCESS : IDLE;
            ACCESS: begin
                gnt = idx_oh;
                mem_we = l_we;
                state_nxt = l_we ? IDLE : RESP;
            end
            RESP: rvalid = idx_oh;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = state != IDLE;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized checks of data_mem_arbiter against a
// transaction-schedule model with its own memory image.
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    typedef struct packed {
        logic [2:0]  gnt;
        logic [2:0]  rvalid;
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
    } rec_t;

    logic clk = 1'b0, reset = 1'b0;
    logic [2:0] req = '0, we = '0;
    logic [47:0] addr = '0, wdata = '0;
    logic [2:0] gnt, rvalid;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic mem_we, busy;

    logic [15:0] mem [0:65535];
    logic mem_init = 1'b0;
    int n_chk = 0, n_fail = 0;
    logic chk_en = 1'b0;

    rec_t q[$];
    rec_t cur = '0;
    logic cur_busy = 1'b0;
    int last = 2;
    logic [15:0] mm [logic [15:0]];
    logic [15:0] e_rdata = '0, e_addr = '0, e_wdata = '0;

    data_mem_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        return mm.exists(a) ? mm[a] : init_val(a);
    endfunction

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
            mem_init <= 1'b1;
        end else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an idle cycle with pending requests schedules an access cycle (and a
    // response cycle for reads) for the following cycles; busy cycles consume the schedule.
    always @(negedge clk) if (chk_en) begin
        int w;
        rec_t r;
        if (!reset) begin
            q.delete();
            cur = '0;
            cur_busy = 1'b0;
            last = 2;
            e_rdata = '0;
            e_addr = '0;
            e_wdata = '0;
        end
        chk("gnt", 16'(gnt), 16'(cur.gnt));
        chk("rvalid", 16'(rvalid), 16'(cur.rvalid));
        chk("busy", 16'(busy), 16'(cur_busy));
        chk("mem_we", 16'(mem_we), 16'((|cur.gnt) & cur.we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("rdata", rdata, e_rdata);
        #2;
        if (reset && !cur_busy && req != 3'b000) begin
            w = -1;
            for (int k = 1; k <= 3 && w < 0; k++)
                if (req[(last + k) % 3]) w = (last + k) % 3;
            last = w;
            r = '0;
            r.gnt = 3'b001 << w;
            r.we = we[w];
            r.a = addr[w*16 +: 16];
            r.d = wdata[w*16 +: 16];
            q.push_back(r);
            if (!r.we) begin
                r.gnt = 3'b000;
                r.rvalid = 3'b001 << w;
                q.push_back(r);
            end
        end
        if (q.size() != 0) begin
            cur = q.pop_front();
            cur_busy = 1'b1;
            if (|cur.gnt) begin
                e_addr = cur.a;
                e_wdata = cur.d;
                if (cur.we) mm[cur.a] = cur.d;
            end
            if (|cur.rvalid) e_rdata = model_rd(cur.a);
        end else begin
            cur = '0;
            cur_busy = 1'b0;
        end
    end

    task automatic new_req(input int i);
        req[i] = 1'b1;
        we[i] = 1'($urandom_range(0, 1));
        addr[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                       : 16'($urandom_range(0, 31));
        wdata[i*16 +: 16] = 16'($urandom);
    endtask

    task automatic agent();
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                if ($urandom_range(0, 3) == 0) new_req(i);
                else req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 2) == 0) new_req(i);
        end
    endtask

    initial begin
        logic [2:0] ord [$];
        logic [2:0] exp_ord [6];
        exp_ord = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        repeat (3) @(negedge clk);
        chk("rst_gnt", 16'(gnt), 16'h0);
        chk("rst_rvalid", 16'(rvalid), 16'h0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_mem_we", 16'(mem_we), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        #1 reset = 1'b1;
        req = 3'b001;
        addr[15:0] = 16'h0020;
        @(negedge clk);
        chk("pre_rst_gnt", 16'(gnt), 16'h1);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("midrst_mem_we", 16'(mem_we), 16'h0);
        chk("midrst_gnt", 16'(gnt), 16'h0);
        @(negedge clk);
        chk("midrst_rvalid", 16'(rvalid), 16'h0);
        req = 3'b111;
        we = 3'b000;
        addr = {16'h0102, 16'h0101, 16'h0100};
        #1 reset = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (gnt != 3'b000) ord.push_back(gnt);
        end
        req = 3'b000;
        chk("order_len", 16'(ord.size()), 16'd6);
        for (int k = 0; k < 6 && k < ord.size(); k++) chk("order", 16'(ord[k]), 16'(exp_ord[k]));
        repeat (2) @(negedge clk);
        req = 3'b010; we = 3'b010; addr[31:16] = 16'h0010; wdata[31:16] = 16'hBEEF;
        @(negedge clk);
        chk("wr_gnt", 16'(gnt), 16'h2);
        chk("wr_mem_we", 16'(mem_we), 16'h1);
        chk("wr_mem_addr", mem_addr, 16'h0010);
        req = 3'b000;
        @(negedge clk);
        chk("wr_mem", mem[16'h0010], 16'hBEEF);
        req = 3'b010; we = 3'b010; addr[31:16] = 16'h0020; wdata[31:16] = 16'h1234;
        @(negedge clk);
        req = 3'b000;
        @(negedge clk);
        req = 3'b001; we = 3'b000; addr[15:0] = 16'h0020;
        @(negedge clk);
        chk("rd_gnt", 16'(gnt), 16'h1);
        req = 3'b000;
        @(negedge clk);
        chk("rd_rvalid", 16'(rvalid), 16'h1);
        chk("rd_rdata", rdata, 16'h1234);
        @(negedge clk);
        req = 3'b001; we = 3'b001; addr[15:0] = 16'hFFFF; wdata[15:0] = 16'h00AA;
        @(negedge clk);
        chk("wrap_wr_addr", mem_addr, 16'hFFFF);
        req = 3'b000;
        @(negedge clk);
        req = 3'b001; we = 3'b000;
        @(negedge clk);
        chk("wrap_rd_gnt", 16'(gnt), 16'h1);
        req = 3'b000;
        @(negedge clk);
        chk("wrap_rvalid", 16'(rvalid), 16'h1);
        chk("wrap_rdata", rdata, 16'h00AA);
        @(negedge clk);
        req = 3'b010; we = 3'b000; addr[31:16] = 16'h0005;
        @(negedge clk);
        chk("late_gnt1", 16'(gnt), 16'h2);
        req = 3'b000;
        @(negedge clk);
        req = 3'b100; we = 3'b100; addr[47:32] = 16'h0030; wdata[47:32] = 16'h7777;
        @(negedge clk);
        chk("late_idle_busy", 16'(busy), 16'h0);
        @(negedge clk);
        chk("late_gnt2", 16'(gnt), 16'h4);
        req = 3'b000;
        repeat (3000) begin
            @(negedge clk);
            agent();
        end
        req = 3'b000;
        repeat (6) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
